// File: rtl/uart_tx.sv
// uart_tx: one-frame-per-byte UART transmitter paced only by the external baud_en strobe.
// Optional parity bit and parity_odd port are enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
    parameter int U_DLY     = 1,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              baud_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_odd,
`endif
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              uart_txd
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [2:0] LAST_DATA = 3'(DATA_W - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    // Out-of-range parameters land in this empty block; U_DLY is accepted for
    // compatibility with delay-annotated netlists but is not modelled here.
    if (DATA_W < 5 || DATA_W > 8 || (STOP_BITS != 1 && STOP_BITS != 2) || U_DLY < 0)
    begin : g_illegal_params
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              txd_q, txd_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic accept;
    assign accept = tx_valid && ready_q;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ALIGN;
                    shift_d = tx_data;
                    ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ parity_odd;
`endif
                end
            end
            // Waiting for a fresh strobe guarantees a full-length start bit.
            ALIGN: begin
                if (baud_en) begin
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_en) begin
                    state_d   = DATA;
                    txd_d     = shift_q[0];
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (baud_en) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        txd_d     = parity_q;
`else
                        state_d   = STOP;
                        txd_d     = 1'b1;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_en) begin
                    state_d   = STOP;
                    txd_d     = 1'b1;
                    bit_cnt_d = 3'd0;
                end
            end
`endif
            STOP: begin
                if (baud_en) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        ready_d   = 1'b1;
                        done_d    = 1'b1;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= 3'd0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign uart_txd = txd_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a free-running strobe every 4 clocks.
// Covers reset, single byte, parity (UART_TX_PARITY_EN), 7N2, back-to-back, busy-ignore, mid-frame reset.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    // Frame bit i = i-th bit on the line (start first); parity_odd = 0 unless noted.
    localparam logic [15:0] F_A5     = 16'h054A;
    localparam logic [15:0] F_A5_ODD = 16'h074A;
    localparam logic [15:0] F_01     = 16'h0602;
    localparam logic [15:0] F_80     = 16'h0700;
    localparam logic [15:0] F_00     = 16'h0400;
    localparam logic [15:0] F_3C     = 16'h0478;
    localparam logic [15:0] F_7F_7N2 = 16'h07FE;
`else
    localparam int P = 0;
    localparam logic [15:0] F_A5     = 16'h034A;
    localparam logic [15:0] F_01     = 16'h0202;
    localparam logic [15:0] F_80     = 16'h0300;
    localparam logic [15:0] F_00     = 16'h0200;
    localparam logic [15:0] F_3C     = 16'h0278;
    localparam logic [15:0] F_7F_7N2 = 16'h03FE;
`endif
    localparam int NB = 10 + P;  // both instances carry 10 bits plus optional parity

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       baud_en = 1'b0;
    logic [7:0] tx_data8  = 8'h00;
    logic       tx_valid8 = 1'b0;
    logic [6:0] tx_data7  = 7'h00;
    logic       tx_valid7 = 1'b0;
    logic       parity_odd = 1'b0;
    logic       ready8, busy8, done8, txd8;
    logic       ready7, busy7, done7, txd7;
    int         div = 0;
    int         vectors = 0;
    int         miscompares = 0;

    uart_tx #(.U_DLY(1), .DATA_W(8), .STOP_BITS(1)) u_dut8 (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .baud_en (baud_en),
        .tx_data (tx_data8),
        .tx_valid(tx_valid8),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx_ready(ready8),
        .tx_busy (busy8),
        .tx_done (done8),
        .uart_txd(txd8)
    );

    uart_tx #(.U_DLY(1), .DATA_W(7), .STOP_BITS(2)) u_dut7 (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .baud_en (baud_en),
        .tx_data (tx_data7),
        .tx_valid(tx_valid7),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx_ready(ready7),
        .tx_busy (busy7),
        .tx_done (done7),
        .uart_txd(txd7)
    );

    always #5 clk_sys = ~clk_sys;

    // Strobe high for one cycle in every four, changing on the falling edge.
    always @(negedge clk_sys) begin
        div = (div + 1) % 4;
        baud_en = (div == 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic mon_txd(input int sel);
        return (sel == 0) ? txd8 : txd7;
    endfunction

    function automatic logic mon_done(input int sel);
        return (sel == 0) ? done8 : done7;
    endfunction

    function automatic logic mon_ready(input int sel);
        return (sel == 0) ? ready8 : ready7;
    endfunction

    task automatic send(input int sel, input logic [7:0] data, input bit hold);
        if (sel == 0) begin
            tx_data8  = data;
            tx_valid8 = 1'b1;
        end else begin
            tx_data7  = data[6:0];
            tx_valid7 = 1'b1;
        end
        @(negedge clk_sys);
        if (!hold) begin
            tx_valid8 = 1'b0;
            tx_valid7 = 1'b0;
        end
    endtask

    // Finds the start bit (bounded), then records one sample per bit plus handshake timing.
    task automatic capture(input int sel, input int nbits, output logic [15:0] bits,
                           output int waited, output int done_at, output int done_cnt,
                           output logic rdy_before, output logic rdy_after, output int unstable);
        logic t;
        bits = '0; waited = 0; done_at = -1; done_cnt = 0; unstable = 0;
        rdy_before = 1'bx; rdy_after = 1'bx;
        while (mon_txd(sel) !== 1'b0 && waited < 200) begin
            @(negedge clk_sys);
            waited++;
        end
        if (mon_txd(sel) !== 1'b0) begin
            waited = -1;
            return;
        end
        for (int j = 0; j <= nbits * 4 + 1; j++) begin
            t = mon_txd(sel);
            if (j < nbits * 4) begin
                if (j % 4 == 0) bits[j / 4] = t;
                else if (t !== bits[j / 4]) unstable++;
            end
            if (mon_done(sel) === 1'b1) begin
                if (done_at < 0) done_at = j;
                done_cnt++;
            end
            if (j == nbits * 4 - 1) rdy_before = mon_ready(sel);
            if (j == nbits * 4) rdy_after = mon_ready(sel);
            if (j != nbits * 4 + 1) @(negedge clk_sys);
        end
    endtask

    task automatic test_reset();
        int lows, busies;
        repeat (3) @(negedge clk_sys);
        vectors++;
        if ({txd8, ready8, busy8, done8} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_outputs8: txd/ready/busy/done=%b, required 1100", {txd8, ready8, busy8, done8});
        end
        vectors++;
        if ({txd7, ready7, busy7, done7} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_outputs7: txd/ready/busy/done=%b, required 1100", {txd7, ready7, busy7, done7});
        end
        rst_n = 1'b1;
        lows = 0; busies = 0;
        repeat (12) begin
            @(negedge clk_sys);
            if (txd8 !== 1'b1) lows++;
            if (busy8 !== 1'b0 || done8 !== 1'b0) busies++;
        end
        vectors++;
        if (lows !== 0 || busies !== 0) begin
            miscompares++;
            $display("FAIL idle_strobes: %0d low and %0d busy/done cycles, required 0 and 0", lows, busies);
        end
    endtask

    // Acceptance lands on a strobe edge; that strobe must not be used for alignment.
    task automatic test_single();
        logic [15:0] b; int w, d, c, u, n; logic rb, ra;
        n = 0;
        do begin
            @(negedge clk_sys);
            #1;
            n++;
        end while (baud_en !== 1'b1 && n < 10);
        send(0, 8'hA5, 1'b0);
        n = 0;
        while (txd8 !== 1'b0 && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL align_delay: start bit after %0d cycles, required 4", n);
        end
        capture(0, NB, b, w, d, c, rb, ra, u);
        vectors++;
        if (b !== F_A5 || u !== 0) begin
            miscompares++;
            $display("FAIL a5_frame: bits=%h unstable=%0d, required %h and 0", b, u, F_A5);
        end
        vectors++;
        if (d !== NB * 4 || c !== 1) begin
            miscompares++;
            $display("FAIL a5_done: at %0d count %0d, required at %0d count 1", d, c, NB * 4);
        end
        vectors++;
        if (rb !== 1'b0 || ra !== 1'b1) begin
            miscompares++;
            $display("FAIL a5_ready: before/after=%b%b, required 01", rb, ra);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] b; int w, d, c, u; logic rb, ra;
        parity_odd = 1'b1;
        send(0, 8'hA5, 1'b0);
        capture(0, NB, b, w, d, c, rb, ra, u);
        parity_odd = 1'b0;
        vectors++;
        if (b !== F_A5_ODD || u !== 0) begin
            miscompares++;
            $display("FAIL a5_odd_frame: bits=%h unstable=%0d, required %h and 0", b, u, F_A5_ODD);
        end
        vectors++;
        if (d !== NB * 4 || c !== 1) begin
            miscompares++;
            $display("FAIL a5_odd_done: at %0d count %0d, required at %0d count 1", d, c, NB * 4);
        end
    endtask
`endif

    task automatic test_stop2_dw7();
        logic [15:0] b; int w, d, c, u; logic rb, ra;
        send(1, 8'h7F, 1'b0);
        capture(1, NB, b, w, d, c, rb, ra, u);
        vectors++;
        if (b !== F_7F_7N2 || u !== 0) begin
            miscompares++;
            $display("FAIL 7n2_frame: bits=%h unstable=%0d, required %h and 0", b, u, F_7F_7N2);
        end
        vectors++;
        if (d !== NB * 4 || c !== 1) begin
            miscompares++;
            $display("FAIL 7n2_done: at %0d count %0d, required at %0d count 1", d, c, NB * 4);
        end
        vectors++;
        if (rb !== 1'b0 || ra !== 1'b1) begin
            miscompares++;
            $display("FAIL 7n2_ready: before/after=%b%b, required 01", rb, ra);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b1, b2; int w1, w2, d1, d2, c1, c2, u1, u2; logic rb1, ra1, rb2, ra2;
        send(0, 8'h01, 1'b1);
        tx_data8 = 8'h80;
        capture(0, NB, b1, w1, d1, c1, rb1, ra1, u1);
        tx_valid8 = 1'b0;
        capture(0, NB, b2, w2, d2, c2, rb2, ra2, u2);
        vectors++;
        if (b1 !== F_01 || b2 !== F_80 || u1 !== 0 || u2 !== 0) begin
            miscompares++;
            $display("FAIL b2b_frames: %h,%h (unstable %0d,%0d), required %h,%h", b1, b2, u1, u2, F_01, F_80);
        end
        vectors++;
        if ({rb1, ra1, rb2, ra2} !== 4'b0101 || c1 !== 1 || c2 !== 1) begin
            miscompares++;
            $display("FAIL b2b_handshake: ready=%b done counts %0d,%0d, required 0101 and 1,1",
                     {rb1, ra1, rb2, ra2}, c1, c2);
        end
        vectors++;
        if (NB * 4 + 1 + w2 !== NB * 4 + 4) begin
            miscompares++;
            $display("FAIL b2b_gap: start-to-start %0d cycles, required %0d", NB * 4 + 1 + w2, NB * 4 + 4);
        end
    endtask

    task automatic test_busy_ignore();
        logic [15:0] b; int w, d, c, u, lows; logic rb, ra;
        send(0, 8'h00, 1'b0);
        tx_data8  = 8'hFF;
        tx_valid8 = 1'b1;
        @(negedge clk_sys);
        tx_valid8 = 1'b0;
        capture(0, NB, b, w, d, c, rb, ra, u);
        vectors++;
        if (b !== F_00 || u !== 0) begin
            miscompares++;
            $display("FAIL busy_frame: bits=%h unstable=%0d, required %h and 0", b, u, F_00);
        end
        lows = 0;
        repeat (60) begin
            @(negedge clk_sys);
            if (txd8 !== 1'b1 || ready8 !== 1'b1) lows++;
        end
        vectors++;
        if (lows !== 0) begin
            miscompares++;
            $display("FAIL busy_no_second_frame: %0d active cycles after frame, required 0", lows);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] b; int w, d, c, u, n; logic rb, ra;
        send(0, 8'h00, 1'b0);
        n = 0;
        while (txd8 !== 1'b0 && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (17) @(negedge clk_sys);
        vectors++;
        if ({txd8, ready8, busy8} !== 3'b001) begin
            miscompares++;
            $display("FAIL mid_frame_state: txd/ready/busy=%b, required 001", {txd8, ready8, busy8});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({txd8, ready8, busy8, done8} !== 4'b1100) begin
            miscompares++;
            $display("FAIL async_reset: txd/ready/busy/done=%b, required 1100", {txd8, ready8, busy8, done8});
        end
        @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        send(0, 8'h3C, 1'b0);
        capture(0, NB, b, w, d, c, rb, ra, u);
        vectors++;
        if (b !== F_3C || u !== 0 || d !== NB * 4) begin
            miscompares++;
            $display("FAIL post_reset_frame: bits=%h unstable=%0d done_at=%0d, required %h, 0, %0d",
                     b, u, d, F_3C, NB * 4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_stop2_dw7();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
